// File: rtl/oven_pkg.sv
// ============================================================================
// Module : oven_pkg
// Brief  : Shared phase encoding, limits and saturating helpers for the oven
//          heater controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package oven_pkg;

    localparam int TEMP_W = 11;
    localparam int TIME_W = 16;

    localparam logic [TEMP_W-1:0] TEMP_MIN     = 11'd60;
    localparam logic [TEMP_W-1:0] TEMP_MAX     = 11'd900;
    localparam logic [TIME_W-1:0] TIME_MAX     = 16'd3600;
    localparam logic [TEMP_W-1:0] PREHEAT_BAND = 11'd5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREHEAT = 3'd1,
        BAKE    = 3'd2,
        DONE    = 3'd3
    } phase_e;

    function automatic logic [TEMP_W-1:0] clamp_temp(input logic [TEMP_W-1:0] t);
        if (t < TEMP_MIN) return TEMP_MIN;
        if (t > TEMP_MAX) return TEMP_MAX;
        return t;
    endfunction

    function automatic logic [TIME_W-1:0] clamp_time(input logic [TIME_W-1:0] t);
        if (t > TIME_MAX) return TIME_MAX;
        return t;
    endfunction

    // Heating never lowers a temperature that is already above the ceiling.
    function automatic logic [TEMP_W-1:0] temp_rise(
        input logic [TEMP_W-1:0] t,
        input logic [TEMP_W-1:0] step,
        input logic [TEMP_W-1:0] ceil
    );
        logic [TEMP_W:0] sum;
        sum = {1'b0, t} + {1'b0, step};
        if (t >= ceil) return t;
        if (sum >= {1'b0, ceil}) return ceil;
        return sum[TEMP_W-1:0];
    endfunction

    function automatic logic [TEMP_W-1:0] temp_fall(
        input logic [TEMP_W-1:0] t,
        input logic [TEMP_W-1:0] step,
        input logic [TEMP_W-1:0] floor
    );
        logic [TEMP_W:0] lim;
        lim = {1'b0, floor} + {1'b0, step};
        if ({1'b0, t} <= lim) return floor;
        return t - step;
    endfunction

endpackage

`default_nettype wire

// File: rtl/oven_tick_gen.sv
// ============================================================================
// Module : oven_tick_gen
// Brief  : Free-running TICK_DIV prescaler with synchronous clear; tick is high
//          for the single cycle in which the count sits at TICK_DIV-1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module oven_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int               c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TICK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/oven_heater_ctrl.sv
// ============================================================================
// Module : oven_heater_ctrl
// Brief  : Command responder and preheat/bake/cool-down sequencer driving the
//          heating element from a 1 s thermal model. OVEN_DOOR_INTERLOCK_EN
//          adds a door_open input that pauses heating and the countdown.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module oven_heater_ctrl
    import oven_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int AMBIENT   = 60,
    parameter int HEAT_STEP = 2,
    parameter int COOL_STEP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [TEMP_W-1:0] cmd_target,
    input  logic [TIME_W-1:0] cmd_time,
    input  logic              abort,
    input  logic              alarm_ack,
`ifdef OVEN_DOOR_INTERLOCK_EN
    input  logic              door_open,
`endif
    output logic [TEMP_W-1:0] temp,
    output logic [TIME_W-1:0] remaining,
    output logic [2:0]        phase,
    output logic              heater_on,
    output logic              preheat_done,
    output logic              bake_done,
    output logic              alarm
);

    localparam logic [TEMP_W-1:0] c_ambient = TEMP_W'(AMBIENT);
    localparam logic [TEMP_W-1:0] c_heat    = TEMP_W'(HEAT_STEP);
    localparam logic [TEMP_W-1:0] c_cool    = TEMP_W'(COOL_STEP);

    phase_e            r_state;
    phase_e            w_state_nxt;
    logic [TEMP_W-1:0] r_temp;
    logic [TEMP_W-1:0] r_target;
    logic [TIME_W-1:0] r_remaining;
    logic              r_alarm;

    logic w_tick;
    logic w_door;
    logic w_accept;
    logic w_abort_run;
    logic w_in_band;
    logic w_run_free;
    logic w_preheat_hit;
    logic w_bake_hit;

`ifdef OVEN_DOOR_INTERLOCK_EN
    assign w_door = door_open;
`else
    assign w_door = 1'b0;
`endif

    oven_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .tick (w_tick)
    );

    assign w_accept    = cmd_valid && cmd_ready;
    assign w_abort_run = abort && ((r_state == PREHEAT) || (r_state == BAKE));
    // temp >= target-5, rearranged so the subtraction cannot underflow.
    assign w_in_band   = ({1'b0, r_temp} + {1'b0, PREHEAT_BAND}) >= {1'b0, r_target};
    assign w_run_free  = !abort && !w_door;

    assign w_preheat_hit = (r_state == PREHEAT) && w_run_free && w_in_band;
    assign w_bake_hit    = (r_state == BAKE) && w_run_free && (r_remaining == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (w_accept) w_state_nxt = PREHEAT;
            end
            PREHEAT: begin
                if (abort)              w_state_nxt = IDLE;
                else if (w_preheat_hit) w_state_nxt = BAKE;
            end
            BAKE: begin
                if (abort)           w_state_nxt = IDLE;
                else if (w_bake_hit) w_state_nxt = DONE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        heater_on = 1'b0;
        case (r_state)
            IDLE, DONE: cmd_ready = !w_door;
            PREHEAT:    heater_on = w_run_free;
            BAKE:       heater_on = w_run_free && !w_in_band;
            default:    heater_on = 1'b0;
        endcase
        preheat_done = w_preheat_hit && !rst;
        bake_done    = w_bake_hit && !rst;
    end

    // The tick step follows heater_on, which reflects the pre-transition state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_temp <= c_ambient;
        end else if (w_tick && !w_abort_run) begin
            if (heater_on) begin
                r_temp <= temp_rise(r_temp, c_heat, r_target);
            end else begin
                r_temp <= temp_fall(r_temp, c_cool, c_ambient);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_target <= TEMP_MIN;
        end else if (w_accept) begin
            r_target <= clamp_temp(cmd_target);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_remaining <= '0;
        end else if (w_accept) begin
            r_remaining <= clamp_time(cmd_time);
        end else if (w_abort_run) begin
            r_remaining <= '0;
        end else if ((r_state == BAKE) && w_tick && !w_door && (r_remaining != '0)) begin
            r_remaining <= r_remaining - 1'b1;
        end
    end

    // Completion has priority over an acknowledge arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alarm <= 1'b0;
        end else if (w_bake_hit) begin
            r_alarm <= 1'b1;
        end else if (alarm_ack || w_accept) begin
            r_alarm <= 1'b0;
        end
    end

    assign temp      = r_temp;
    assign remaining = r_remaining;
    assign phase     = r_state;
    assign alarm     = r_alarm;

endmodule

`default_nettype wire

// File: tb/tb_oven_heater_ctrl.sv
// ============================================================================
// Module : tb_oven_heater_ctrl
// Brief  : Self-checking bench for oven_heater_ctrl with a cycle reference
//          model feeding a scoreboard queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_oven_heater_ctrl;
    import oven_pkg::*;

    localparam int TICK_DIV  = 4;
    localparam int AMBIENT   = 60;
    localparam int HEAT_STEP = 2;
    localparam int COOL_STEP = 1;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_target;
    logic [15:0] cmd_time;
    logic        abort;
    logic        alarm_ack;
    logic        door_open;
    logic [10:0] temp;
    logic [15:0] remaining;
    logic [2:0]  phase;
    logic        heater_on;
    logic        preheat_done;
    logic        bake_done;
    logic        alarm;

    oven_heater_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .AMBIENT   (AMBIENT),
        .HEAT_STEP (HEAT_STEP),
        .COOL_STEP (COOL_STEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_target   (cmd_target),
        .cmd_time     (cmd_time),
        .abort        (abort),
        .alarm_ack    (alarm_ack),
`ifdef OVEN_DOOR_INTERLOCK_EN
        .door_open    (door_open),
`endif
        .temp         (temp),
        .remaining    (remaining),
        .phase        (phase),
        .heater_on    (heater_on),
        .preheat_done (preheat_done),
        .bake_done    (bake_done),
        .alarm        (alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    typedef struct {
        int temp;
        int rem;
        int phase;
        int alarm;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    int m_state = 0;
    int m_temp  = AMBIENT;
    int m_target = 60;
    int m_rem   = 0;
    int m_alarm = 0;
    int m_cnt   = 0;

    // Event observations
    int hon_cnt = 0;
    int pd_cnt  = 0;
    int pd_temp = 0;
    int bd_cnt  = 0;
    int log_rem = 0;
    int rem_log[$];

    // Called just after a negedge with inputs already driven.
    task automatic step();
        int door, tick, ready, acc, abrt, band, heat, pdone, bdone;
        int n_temp, n_rem, n_state, n_alarm;
        exp_t e;
        door = 0;
`ifdef OVEN_DOOR_INTERLOCK_EN
        door = int'(door_open);
`endif
        tick  = (m_cnt == TICK_DIV - 1);
        ready = ((m_state == 0) || (m_state == 3)) && !door;
        acc   = cmd_valid && ready;
        abrt  = abort && ((m_state == 1) || (m_state == 2));
        band  = (m_temp + 5 >= m_target);
        heat = 0; pdone = 0; bdone = 0;
        if (m_state == 1) begin
            heat  = !door && !abort;
            pdone = !door && !abort && band;
        end else if (m_state == 2) begin
            heat  = !door && !abort && !band;
            bdone = !door && !abort && (m_rem == 0);
        end
        if (rst) begin
            pdone = 0;
            bdone = 0;
        end
        #1;
        if (!rst) begin
            check("cmd_ready", cmd_ready, ready);
            check("heater_on", heater_on, heat);
        end
        check("preheat_done", preheat_done, pdone);
        check("bake_done", bake_done, bdone);
        if (heater_on) hon_cnt++;
        if (preheat_done) begin
            pd_cnt++;
            pd_temp = temp;
        end
        if (bake_done) bd_cnt++;

        if (rst) begin
            n_temp = AMBIENT; n_rem = 0; n_state = 0; n_alarm = 0;
            m_target = 60;
            m_cnt = 0;
        end else begin
            n_temp = m_temp;
            if (tick && !abrt) begin
                if (heat) begin
                    if (m_temp < m_target)
                        n_temp = (m_temp + HEAT_STEP >= m_target) ? m_target : m_temp + HEAT_STEP;
                end else begin
                    n_temp = (m_temp <= AMBIENT + COOL_STEP) ? AMBIENT : m_temp - COOL_STEP;
                end
            end
            if (acc)       n_rem = (cmd_time > 3600) ? 3600 : int'(cmd_time);
            else if (abrt) n_rem = 0;
            else if (m_state == 2 && tick && !door && m_rem > 0) n_rem = m_rem - 1;
            else           n_rem = m_rem;
            if (acc)        n_state = 1;
            else if (abrt)  n_state = 0;
            else if (pdone) n_state = 2;
            else if (bdone) n_state = 3;
            else            n_state = m_state;
            if (bdone)                  n_alarm = 1;
            else if (alarm_ack || acc)  n_alarm = 0;
            else                        n_alarm = m_alarm;
            if (acc) m_target = (cmd_target < 60) ? 60 : (cmd_target > 900) ? 900 : int'(cmd_target);
            m_cnt = tick ? 0 : m_cnt + 1;
        end
        m_temp = n_temp; m_rem = n_rem; m_state = n_state; m_alarm = n_alarm;
        e.temp = n_temp; e.rem = n_rem; e.phase = n_state; e.alarm = n_alarm;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("temp", temp, e.temp);
        check("remaining", remaining, e.rem);
        check("phase", phase, e.phase);
        check("alarm", alarm, e.alarm);
        if (log_rem != 0 && phase == BAKE &&
            (rem_log.size() == 0 || int'(remaining) != rem_log[$]))
            rem_log.push_back(remaining);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input int tgt, input int tm);
        cmd_valid  = 1'b1;
        cmd_target = 11'(tgt);
        cmd_time   = 16'(tm);
        step();
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_phase(input int ph, input int budget, input string tag);
        for (int i = 0; i < budget && int'(phase) != ph; i++) step();
        check(tag, phase, ph);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, bd0, exp_rem[4];
        rst = 1'b1; cmd_valid = 1'b0; cmd_target = '0; cmd_time = '0;
        abort = 1'b0; alarm_ack = 1'b0; door_open = 1'b0;
        @(negedge clk);

        // 1. Reset and idle
        run(3);
        rst = 1'b0;
        check("rst_temp", temp, 60);
        check("rst_phase", phase, IDLE);
        check("rst_ready", cmd_ready, 1);
        check("rst_remaining", remaining, 0);
        hon_cnt = 0;
        run(20 * TICK_DIV);
        check("idle_temp", temp, 60);
        check("idle_heater_cycles", hon_cnt, 0);

        // 2. Preheat and bake
        send(80, 3);
        check("pre_phase", phase, PREHEAT);
        check("pre_heater", heater_on, 1);
        pd_cnt = 0; bd_cnt = 0;
        rem_log.delete();
        log_rem = 1;
        wait_phase(BAKE, 60, "reach_bake");
        check("preheat_pulses", pd_cnt, 1);
        check("preheat_temp", pd_temp, 76);
        wait_phase(DONE, 40, "reach_done");
        log_rem = 0;
        exp_rem = '{3, 2, 1, 0};
        check("rem_steps", rem_log.size(), 4);
        for (int i = 0; i < 4 && i < rem_log.size(); i++) check("rem_seq", rem_log[i], exp_rem[i]);
        check("bake_pulses", bd_cnt, 1);
        check("done_alarm", alarm, 1);

        // 3. Clamping
        send(1000, 5000);
        check("clamp_time", remaining, 3600);
        check("accept_clears_alarm", alarm, 0);
        run(2);
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_pre_phase", phase, IDLE);
        send(20, 7);
        wait_phase(BAKE, 4, "low_target_bake");
        check("low_target_rem", remaining, 7);
        abort = 1'b1; step(); abort = 1'b0;

        // 4. Abort mid-bake coincident with tick
        send(90, 20);
        wait_phase(BAKE, 80, "bake90");
        cmd_valid = 1'b1; cmd_target = 11'd100; cmd_time = 16'd9;
        run(6);
        cmd_valid = 1'b0;
        check("busy_phase", phase, BAKE);
        check("busy_not_accepted", remaining == 16'd9, 0);
        for (int i = 0; i < 8 && m_cnt != TICK_DIV - 1; i++) step();
        t0 = temp; bd0 = bd_cnt;
        abort = 1'b1; step(); abort = 1'b0;
        check("abort_phase", phase, IDLE);
        check("abort_rem", remaining, 0);
        check("abort_temp_hold", temp, t0);
        check("abort_no_done", bd_cnt, bd0);

        // 5. Alarm handling
        send(60, 2);
        wait_phase(DONE, 40, "alarm_run_done");
        check("alarm_set", alarm, 1);
        alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
        check("alarm_acked", alarm, 0);
        send(60, 1);
        bd0 = bd_cnt;
        for (int i = 0; i < 40; i++) begin
            if (m_state == 2 && m_rem == 0) begin
                alarm_ack = 1'b1; step(); alarm_ack = 1'b0;
                break;
            end
            step();
        end
        check("ack_with_done_pulse", bd_cnt, bd0 + 1);
        check("ack_with_done_alarm", alarm, 1);
        check("ack_with_done_phase", phase, DONE);
        alarm_ack = 1'b1; send(60, 1); alarm_ack = 1'b0;
        check("accept_ack_alarm", alarm, 0);
        wait_phase(DONE, 40, "cooldown_done");
        run(120);

        // 6. Reset mid-preheat, then door interlock
        send(200, 5);
        for (int i = 0; i < 60 && temp != 11'd70; i++) step();
        check("pre70_temp", temp, 70);
        check("pre70_phase", phase, PREHEAT);
        rst = 1'b1; step(); rst = 1'b0;
        check("midrst_temp", temp, 60);
        check("midrst_phase", phase, IDLE);
        check("midrst_rem", remaining, 0);
        check("midrst_heater", heater_on, 0);
        check("midrst_ready", cmd_ready, 1);
`ifdef OVEN_DOOR_INTERLOCK_EN
        send(60, 10);
        wait_phase(BAKE, 8, "door_bake");
        check("door_rem_start", remaining, 10);
        door_open = 1'b1;
        hon_cnt = 0;
        run(5 * TICK_DIV);
        check("door_rem_frozen", remaining, 10);
        check("door_heater_cycles", hon_cnt, 0);
        check("door_phase_held", phase, BAKE);
        check("door_ready", cmd_ready, 0);
        door_open = 1'b0;
        run(5 * TICK_DIV);
        check("door_resumed", remaining < 16'd10, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
